// File: rtl/sync_up_counter_pkg.sv
// Shared types and helpers for the synchronous modulo-N up counter.
package sync_up_counter_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    localparam int unsigned MIN_MODULUS = 2;
    localparam int unsigned MAX_WIDTH   = 31;

    function automatic bit params_legal(int unsigned width, int unsigned modulus);
        return (width >= 1) && (width <= MAX_WIDTH) &&
               (modulus >= MIN_MODULUS) && (modulus <= (32'd1 << width));
    endfunction

    // Out-of-range load requests saturate to the terminal count.
    function automatic int unsigned clamp_load(int unsigned val, int unsigned modulus);
        return (val >= modulus) ? modulus - 1 : val;
    endfunction

endpackage

// File: rtl/sync_up_counter_if.sv
// Control and status bundle between a sequencer and sync_up_counter.
interface sync_up_counter_if #(
    parameter int unsigned WIDTH = 4
);
    logic             en;
    logic             start;
    logic             stop;
    logic             load;
    logic [WIDTH-1:0] load_val;
    logic [WIDTH-1:0] q;
    logic             tc;
    logic             wrap;
    logic             busy;
    logic             done;

    modport master (
        output en, start, stop, load, load_val,
        input  q, tc, wrap, busy, done
    );

    modport slave (
        input  en, start, stop, load, load_val,
        output q, tc, wrap, busy, done
    );
endinterface

// File: rtl/sync_up_counter_up_cnt_core.sv
// Count register with modulus compare, clamped load and registered wrap pulse.
module up_cnt_core
    import sync_up_counter_pkg::*;
#(
    parameter int unsigned WIDTH   = 4,
    parameter int unsigned MODULUS = 10
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             inc,
    input  logic             ld,
    input  logic [WIDTH-1:0] ld_val,
    output logic [WIDTH-1:0] q,
    output logic             tc,
    output logic             wrap
);
    localparam logic [WIDTH-1:0] Q_LAST = WIDTH'(MODULUS - 1);

    logic [WIDTH:0]   q_inc;
    logic [WIDTH-1:0] ld_clamped;
    logic             roll;

    assign q_inc      = {1'b0, q} + (WIDTH + 1)'(1);
    assign tc         = (q == Q_LAST);
    // Carry-out also forces a return to 0, so the count never passes through 2^WIDTH.
    assign roll       = tc || q_inc[WIDTH];
    assign ld_clamped = WIDTH'(clamp_load(32'(ld_val), MODULUS));

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            q    <= '0;
            wrap <= 1'b0;
        end else if (ld) begin
            q    <= ld_clamped;
            wrap <= 1'b0;
        end else if (inc) begin
            q    <= roll ? '0 : q_inc[WIDTH-1:0];
            wrap <= roll;
        end else begin
            wrap <= 1'b0;
        end
    end
endmodule

// File: rtl/sync_up_counter.sv
// Synchronous modulo-N up counter: run/stop/one-shot control around up_cnt_core.
module sync_up_counter
    import sync_up_counter_pkg::*;
#(
    parameter int unsigned WIDTH    = 4,
    parameter int unsigned MODULUS  = 10,
    parameter bit          ONE_SHOT = 1'b0
) (
    input  logic                 clk,
    input  logic                 rst,
    sync_up_counter_if.slave     bus
);
    if (!params_legal(WIDTH, MODULUS)) begin : g_illegal_params
        $error("sync_up_counter: MODULUS must lie in 2..2**WIDTH");
    end

    state_t state;
    logic   inc;

    assign inc = (state == RUN) && bus.en && !bus.load && !bus.stop;

    up_cnt_core #(
        .WIDTH   (WIDTH),
        .MODULUS (MODULUS)
    ) u_core (
        .clk    (clk),
        .rst    (rst),
        .inc    (inc),
        .ld     (bus.load),
        .ld_val (bus.load_val),
        .q      (bus.q),
        .tc     (bus.tc),
        .wrap   (bus.wrap)
    );

    // Load freezes the state; otherwise stop beats start, start beats the roll.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state    <= IDLE;
            bus.busy <= 1'b0;
            bus.done <= 1'b0;
        end else if (!bus.load) begin
            if (bus.stop) begin
                state    <= IDLE;
                bus.busy <= 1'b0;
                bus.done <= 1'b0;
            end else begin
                unique case (state)
                    IDLE, DONE: begin
                        if (bus.start) begin
                            state    <= RUN;
                            bus.busy <= 1'b1;
                            bus.done <= 1'b0;
                        end
                    end
                    RUN: begin
                        if (ONE_SHOT && bus.en && bus.tc) begin
                            state    <= DONE;
                            bus.busy <= 1'b0;
                            bus.done <= 1'b1;
                        end
                    end
                    default: begin
                        state    <= IDLE;
                        bus.busy <= 1'b0;
                        bus.done <= 1'b0;
                    end
                endcase
            end
        end
    end
endmodule

// File: doc/sync_up_counter.md
Name: sync_up_counter

Overview:
- Synchronous modulo-N up counter. It is the count-up counterpart of the team's 4-bit ripple down counter.
- All state elements share one clock. No flip-flop output is used as a clock.
- Adds run/stop control, synchronous load, terminal-count and wrap indications, and an optional one-shot mode.
- Used as the timebase and event counter for downstream sequencers.

Parameters:
- WIDTH, 4, counter width in bits.
- MODULUS, 10, count sequence is 0..MODULUS-1. Legal range is 2 ≤ MODULUS ≤ 2^WIDTH.
- ONE_SHOT, 0, 1 = stop in DONE after the first wrap; 0 = free-run.

Ports:
- clk  input  1  single clock, rising edge active.
- rst  input  1  asynchronous, active-low reset. Asserting it forces the reset state immediately. Release is synchronous to clk.
- en  input  1  count enable. Qualifies increments in RUN only.
- start  input  1  single-cycle request to begin counting.
- stop  input  1  single-cycle request to halt counting. q holds its value.
- load  input  1  synchronous load of load_val.
- load_val  input  WIDTH  value to load.
- q  output  WIDTH  current count.
- tc  output  1  terminal count: combinational, (q == MODULUS-1).
- wrap  output  1  registered one-cycle pulse. High in the cycle q first shows 0 after a MODULUS-1→0 roll.
- busy  output  1  high while in RUN.
- done  output  1  high while in DONE. Only reachable when ONE_SHOT=1.

Behaviour:
- Reset (rst=0): state=IDLE, q=0, wrap=0, busy=0, done=0. tc=0 because MODULUS≥2.
- States: IDLE, RUN, DONE. Encoded per the shared package.
- IDLE:
  - q holds.
  - start=1 → RUN on the next edge. The first increment can occur in the cycle after entering RUN.
- RUN:
  - If en=1: q ← (q==MODULUS-1) ? 0 : q+1. A roll to 0 sets wrap=1 for exactly one cycle.
  - If en=0: q holds and wrap=0.
  - Roll with ONE_SHOT=1 → DONE (q=0, wrap pulses). Roll with ONE_SHOT=0 → stay in RUN.
  - stop=1 → IDLE. q holds and no increment happens that cycle.
  - start=1 in RUN is ignored.
- DONE:
  - q holds at 0.
  - start=1 → RUN. stop=1 → IDLE.
- Priority on any edge: load > stop > start > increment.
- load=1:
  - q ← load_val, or q ← MODULUS-1 if load_val ≥ MODULUS (clamp).
  - State is unchanged and no increment occurs that cycle.
  - wrap=0 in the following cycle.
  - load while the counter sits at MODULUS-1 with en=1 does not generate wrap.
- start and stop together: stop wins (IDLE→IDLE, RUN→IDLE).
- Width rules:
  - The increment is computed in WIDTH+1 bits internally.
  - No wrap through 2^WIDTH is permitted when MODULUS < 2^WIDTH.
  - With MODULUS = 2^WIDTH, the roll occurs at all-ones.
- Reset asserted mid-count: all outputs return to their reset values asynchronously, within the same cycle. In-flight wrap/tc are discarded.
- Latency:
  - start → busy: 1 cycle.
  - en → q change: 1 cycle.
  - load → q: 1 cycle.
  - tc follows q combinationally.

Decomposition:
- Shared package holds:
  - state typedef (IDLE, RUN, DONE);
  - parameter-legality check constants;
  - a function returning the clamped load value.
- Natural sub-module: up_cnt_core. It contains:
  - the WIDTH-bit register, incrementer, modulus compare and wrap register;
  - inputs: clk, rst, inc, ld, ld_val;
  - outputs: q, tc, wrap.
- The top level contains only the control FSM and the busy/done decode.

Test Plan (WIDTH=4, MODULUS=10):
1. Reset, start, en=1 held for 12 cycles → busy=1 after 1 cycle; q runs 1..9. tc=1 while q=9. q rolls to 0 with wrap=1 for one cycle, then continues to 1, 2.
2. Pulse stop at q=6, then start 3 cycles later → q holds at 6 while in IDLE with busy=0. Counting resumes 7, 8, ….
3. load_val=4 during RUN, then load_val=13 → q=4, next count 5. The second load gives q=9 (clamped) with tc=1 and no wrap pulse.
4. ONE_SHOT=1, start, en=1 → after 10 increments q=0, wrap pulses, done=1, busy=0. q stays 0 despite en=1. A new start resumes counting.
5. rst driven low asynchronously mid-cycle at q=7 → q=0, busy=0, wrap=0 without waiting for a clock edge. After release, the counter stays in IDLE until start.
6. start and stop in the same cycle from IDLE; en toggling 1/0 in RUN → state stays IDLE. In RUN, q increments only on cycles with en=1, e.g. 3 en pulses → q=3.
